// File: rtl/dds_sweep_ctrl_if.sv
// Bundle of configuration, control and DDS tuning-word signals for
// dds_sweep_ctrl. The master drives the configuration and control inputs
// and the slave (the sweep controller) drives the tuning words and status.
//
// Handshake: a configuration transfer happens on every rising clock edge
// where cfg_valid && cfg_ready are both high. cfg_ready depends only on the
// controller state, never on cfg_valid. The cfg_* data is sampled on that
// edge only.
interface dds_sweep_ctrl_if #(
    parameter int PHASE_WIDTH = 32,
    parameter int DWELL_WIDTH = 16
);
    logic                   cfg_valid;
    logic                   cfg_ready;
    logic [PHASE_WIDTH-1:0] cfg_start_word;
    logic [PHASE_WIDTH-1:0] cfg_stop_word;
    logic [PHASE_WIDTH-1:0] cfg_step_word;
    logic [DWELL_WIDTH-1:0] cfg_dwell;
    logic [PHASE_WIDTH-1:0] cfg_pha_word;
    logic                   start;
    logic                   abort;
    logic [PHASE_WIDTH-1:0] fre_word;
    logic [PHASE_WIDTH-1:0] pha_word;
    logic                   busy;
    logic                   done;

    modport master (
        output cfg_valid, cfg_start_word, cfg_stop_word, cfg_step_word,
               cfg_dwell, cfg_pha_word, start, abort,
        input  cfg_ready, fre_word, pha_word, busy, done
    );

    modport slave (
        input  cfg_valid, cfg_start_word, cfg_stop_word, cfg_step_word,
               cfg_dwell, cfg_pha_word, start, abort,
        output cfg_ready, fre_word, pha_word, busy, done
    );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep controller feeding a DDS core with Fre_word / Pha_word.
// Steps fre_word from start_word towards stop_word by step_word, holding
// each word for dwell+1 cycles, then pulses done for one cycle.
// Optional feature macro: DDS_SWEEP_TRIANGLE_EN -- when defined, the sweep
// turns round at stop_word and steps back down to start_word before done.
module dds_sweep_ctrl #(
    parameter int PHASE_WIDTH = 32,
    parameter int DWELL_WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    dds_sweep_ctrl_if.slave   bus,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_STEP  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Shadow copy of the last accepted configuration.
    logic [PHASE_WIDTH-1:0] sh_start;
    logic [PHASE_WIDTH-1:0] sh_stop;
    logic [PHASE_WIDTH-1:0] sh_step;
    logic [PHASE_WIDTH-1:0] sh_pha;
    logic [DWELL_WIDTH-1:0] sh_dwell;
    logic                   cfg_loaded;

    // Working copy taken at start, so a configuration accepted in the same
    // cycle as start only affects the next sweep.
    logic [PHASE_WIDTH-1:0] act_stop;
    logic [PHASE_WIDTH-1:0] act_step;
    logic [DWELL_WIDTH-1:0] act_dwell;
    logic                   degen;

    logic [PHASE_WIDTH-1:0] fre_q;
    logic [PHASE_WIDTH-1:0] pha_q;
    logic [DWELL_WIDTH-1:0] cnt;

    logic                   cfg_accept;
    logic                   go;
    logic                   dwell_end;
    logic                   finish;
    logic [PHASE_WIDTH:0]   up_sum;
    logic [PHASE_WIDTH-1:0] word_nxt;

`ifdef DDS_SWEEP_TRIANGLE_EN
    logic [PHASE_WIDTH-1:0] act_start;
    logic                   dir_down;
    logic                   turn;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_nxt  = state;
        go         = 1'b0;
        cfg_accept = bus.cfg_valid && (state == ST_IDLE);
        dwell_end  = (cnt == act_dwell);
`ifdef DDS_SWEEP_TRIANGLE_EN
        turn   = !degen && !dir_down && (fre_q == act_stop);
        finish = degen || (dir_down && (fre_q == act_start));
`else
        finish = degen || (fre_q == act_stop);
`endif
        case (state)
            ST_IDLE: begin
                if (bus.start && cfg_loaded) begin
                    state_nxt = ST_DWELL;
                    go        = 1'b1;
                end
            end
            ST_DWELL: begin
                if (dwell_end) state_nxt = finish ? ST_DONE : ST_STEP;
            end
            ST_STEP: state_nxt = ST_DWELL;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (bus.abort) begin
            state_nxt = ST_IDLE;
            go        = 1'b0;
        end
    end

    // Next tuning word: unsigned sum one bit wider so it can never wrap,
    // clamped at stop_word (and at start_word on the way down).
    always_comb begin
        up_sum   = {1'b0, fre_q} + {1'b0, act_step};
        word_nxt = (up_sum >= {1'b0, act_stop}) ? act_stop : up_sum[PHASE_WIDTH-1:0];
`ifdef DDS_SWEEP_TRIANGLE_EN
        if (dir_down) begin
            word_nxt = ((fre_q - act_start) <= act_step) ? act_start : (fre_q - act_step);
        end
`endif
    end

    // Shadow registers, working copy, tuning words and dwell counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_start   <= '0;
            sh_stop    <= '0;
            sh_step    <= '0;
            sh_pha     <= '0;
            sh_dwell   <= '0;
            cfg_loaded <= 1'b0;
            act_stop   <= '0;
            act_step   <= '0;
            act_dwell  <= '0;
            degen      <= 1'b0;
            fre_q      <= '0;
            pha_q      <= '0;
            cnt        <= '0;
`ifdef DDS_SWEEP_TRIANGLE_EN
            act_start  <= '0;
            dir_down   <= 1'b0;
`endif
        end else begin
            if (cfg_accept) begin
                sh_start   <= bus.cfg_start_word;
                sh_stop    <= bus.cfg_stop_word;
                sh_step    <= bus.cfg_step_word;
                sh_pha     <= bus.cfg_pha_word;
                sh_dwell   <= bus.cfg_dwell;
                cfg_loaded <= 1'b1;
            end
            if (bus.abort) begin
                fre_q <= '0;
                cnt   <= '0;
`ifdef DDS_SWEEP_TRIANGLE_EN
                dir_down <= 1'b0;
`endif
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (go) begin
                            fre_q     <= sh_start;
                            pha_q     <= sh_pha;
                            cnt       <= '0;
                            act_stop  <= sh_stop;
                            act_step  <= sh_step;
                            act_dwell <= sh_dwell;
                            degen     <= (sh_start >= sh_stop) || (sh_step == '0);
`ifdef DDS_SWEEP_TRIANGLE_EN
                            act_start <= sh_start;
                            dir_down  <= 1'b0;
`endif
                        end
                    end
                    ST_DWELL: begin
                        cnt <= cnt + DWELL_WIDTH'(1);
`ifdef DDS_SWEEP_TRIANGLE_EN
                        if (dwell_end && turn) dir_down <= 1'b1;
`endif
                    end
                    ST_STEP: begin
                        cnt   <= '0;
                        fre_q <= word_nxt;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.cfg_ready = (state == ST_IDLE);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.done      = (state == ST_DONE);
    assign bus.fre_word  = fre_q;
    assign bus.pha_word  = pha_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Testbench for dds_sweep_ctrl: directed and random sweeps with a scoreboard
// fed by a word-list reference model and drained by a per-cycle monitor.
module tb_dds_sweep_ctrl;
    localparam int PW = 32;
    localparam int DW = 16;
    localparam int EW = 2 + 2 * PW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    dds_sweep_ctrl_if #(.PHASE_WIDTH(PW), .DWELL_WIDTH(DW)) bus ();

    dds_sweep_ctrl #(.PHASE_WIDTH(PW), .DWELL_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [EW-1:0] exp_q[$];

    // Model of the loaded configuration.
    logic [PW-1:0] m_start, m_stop, m_step, m_pha;
    logic [DW-1:0] m_dwell;
    bit            m_loaded;
    logic [PW-1:0] last_word, last_pha;
    longint        words[$];

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t st=%0d)", name, act, exp, $time, dbg_state);
    endtask

    function automatic logic [EW-1:0] pk(logic b, logic d, logic [PW-1:0] f, logic [PW-1:0] p);
        return {b, d, f, p};
    endfunction

    // Reference: list of words the sweep should visit.
    function automatic void build_words(longint s, longint e, longint st);
        longint w, nxt;
        words.delete();
        if (s >= e || st == 0) begin
            words.push_back(s);
            return;
        end
        w = s;
        for (int k = 0; k < 100000; k++) begin
            words.push_back(w);
            if (w == e) break;
            nxt = w + st;
            w = (nxt >= e) ? e : nxt;
        end
`ifdef DDS_SWEEP_TRIANGLE_EN
        for (int k = 0; k < 100000 && w != s; k++) begin
            w = ((w - s) <= st) ? s : (w - st);
            words.push_back(w);
        end
`endif
    endfunction

    // Per-cycle expectation: each word for dwell+1 cycles, one STEP cycle
    // (old word still shown) between words, then one done cycle.
    task automatic push_trace();
        build_words(longint'(m_start), longint'(m_stop), longint'(m_step));
        for (int i = 0; i < words.size(); i++) begin
            for (int c = 0; c <= int'(m_dwell); c++) exp_q.push_back(pk(1'b1, 1'b0, PW'(words[i]), m_pha));
            if (i < words.size() - 1) exp_q.push_back(pk(1'b1, 1'b0, PW'(words[i]), m_pha));
        end
        last_word = PW'(words[words.size() - 1]);
        last_pha  = m_pha;
        exp_q.push_back(pk(1'b1, 1'b1, last_word, m_pha));
    endtask

    // Monitor: every cycle the DUT is busy must match the next expectation.
    always @(negedge clk) begin
        if (rst_n && (bus.busy || bus.done)) begin
            if (exp_q.size() == 0) check("unexpected_output", pk(bus.busy, bus.done, bus.fre_word, bus.pha_word), '0);
            else check("sweep_trace", pk(bus.busy, bus.done, bus.fre_word, bus.pha_word), exp_q.pop_front());
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 2000) begin
            cycle();
            cyc++;
        end
        check("drain", EW'(exp_q.size()), '0);
        exp_q.delete();
        check("idle_hold", pk(bus.busy, bus.done, bus.fre_word, bus.pha_word), pk(1'b0, 1'b0, last_word, last_pha));
    endtask

    task automatic apply_cfg(input logic [PW-1:0] s, input logic [PW-1:0] e, input logic [PW-1:0] st,
                             input logic [DW-1:0] d, input logic [PW-1:0] p, input bit with_start);
        bus.cfg_valid      = 1'b1;
        bus.cfg_start_word = s;
        bus.cfg_stop_word  = e;
        bus.cfg_step_word  = st;
        bus.cfg_dwell      = d;
        bus.cfg_pha_word   = p;
        bus.start          = with_start;
        if (with_start && m_loaded) push_trace();
        m_start = s; m_stop = e; m_step = st; m_dwell = d; m_pha = p;
        cycle();
        bus.cfg_valid = 1'b0;
        bus.start     = 1'b0;
        if (with_start && exp_q.size() != 0) wait_drain();
        m_loaded = 1'b1;
    endtask

    task automatic start_sweep(input int junk_cycles);
        push_trace();
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        for (int j = 0; j < junk_cycles; j++) begin
            bus.cfg_valid      = 1'b1;
            bus.cfg_start_word = $urandom;
            bus.cfg_stop_word  = $urandom;
            bus.cfg_step_word  = $urandom;
            bus.cfg_dwell      = DW'($urandom);
            bus.cfg_pha_word   = $urandom;
            cycle();
        end
        bus.cfg_valid = 1'b0;
        wait_drain();
    endtask

    task automatic start_ignored(input string name);
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        check(name, EW'(bus.busy), '0);
        cycle();
        check(name, EW'(bus.busy), '0);
    endtask

    initial begin
        bus.cfg_valid = 1'b0; bus.cfg_start_word = '0; bus.cfg_stop_word = '0;
        bus.cfg_step_word = '0; bus.cfg_dwell = '0; bus.cfg_pha_word = '0;
        bus.start = 1'b0; bus.abort = 1'b0;
        m_start = '0; m_stop = '0; m_step = '0; m_dwell = '0; m_pha = '0; m_loaded = 1'b0;
        last_word = '0; last_pha = '0;

        // Reset values.
        repeat (3) cycle();
        check("reset_outputs", pk(bus.busy, bus.done, bus.fre_word, bus.pha_word), '0);
        rst_n = 1'b1;
        cycle();
        check("reset_cfg_ready", EW'(bus.cfg_ready), EW'(1));
        check("reset_idle", pk(bus.busy, bus.done, bus.fre_word, bus.pha_word), '0);

        // Start without a loaded configuration.
        start_ignored("no_cfg_start");

        // Basic up-sweep 100..400 step 100 dwell 2, with cfg traffic while busy.
        apply_cfg(32'd100, 32'd400, 32'd100, 16'd2, 32'h1234, 1'b0);
        start_sweep(3);
        // Shadows untouched by the junk: same sweep again.
        start_sweep(0);

        // Abort in the second dwell.
        push_trace();
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        repeat (5) cycle();
        bus.abort = 1'b1;
        cycle();
        bus.abort = 1'b0;
        check("abort_state", pk(bus.busy, bus.done, bus.fre_word, 32'h0), pk(1'b0, 1'b0, 32'h0, 32'h0));
        exp_q.delete();
        cycle();
        check("abort_no_done", EW'({bus.busy, bus.done}), '0);
        last_word = '0;
        start_sweep(0);

        // Abort in idle clears fre_word.
        bus.abort = 1'b1;
        cycle();
        bus.abort = 1'b0;
        check("abort_idle", pk(bus.busy, bus.done, bus.fre_word, 32'h0), '0);

        // Saturation at stop, and no wrap with a huge step.
        apply_cfg(32'd100, 32'd350, 32'd100, 16'd1, 32'h55, 1'b0);
        start_sweep(0);
        apply_cfg(32'h20, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 16'd0, 32'h0, 1'b0);
        start_sweep(0);

        // Degenerate configurations.
        apply_cfg(32'd500, 32'd400, 32'd10, 16'd3, 32'h9, 1'b0);
        start_sweep(0);
        apply_cfg(32'd10, 32'd400, 32'd0, 16'd1, 32'h8, 1'b0);
        start_sweep(0);
        apply_cfg(32'd77, 32'd77, 32'd5, 16'd0, 32'h7, 1'b0);
        start_sweep(0);

        // cfg and start together: runs the old config, then the new one.
        apply_cfg(32'd1000, 32'd1300, 32'd150, 16'd1, 32'hABCD, 1'b1);
        start_sweep(0);

        // Random sweeps.
        for (int n = 0; n < 25; n++) begin
            logic [PW-1:0] s, e, st;
            int rng;
            s   = $urandom_range(0, 100000);
            rng = $urandom_range(0, 1000);
            e   = ($urandom_range(0, 7) == 0) ? s - PW'($urandom_range(0, 50)) : s + PW'(rng);
            st  = ($urandom_range(0, 7) == 0) ? '0 : PW'(rng / $urandom_range(1, 5) + $urandom_range(1, 20));
            apply_cfg(s, e, st, DW'($urandom_range(0, 4)), $urandom, ($urandom_range(0, 3) == 0));
            start_sweep(($urandom_range(0, 1) == 1) ? 2 : 0);
        end

        // Reset mid-sweep: no done, everything cleared, config forgotten.
        apply_cfg(32'd100, 32'd400, 32'd100, 16'd2, 32'h1234, 1'b0);
        push_trace();
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        repeat (4) cycle();
        rst_n = 1'b0;
        cycle();
        exp_q.delete();
        check("midreset_outputs", pk(bus.busy, bus.done, bus.fre_word, bus.pha_word), '0);
        cycle();
        rst_n = 1'b1;
        m_loaded = 1'b0;
        cycle();
        check("midreset_ready", EW'(bus.cfg_ready), EW'(1));
        start_ignored("midreset_unloaded");
        apply_cfg(32'd5, 32'd25, 32'd7, 16'd1, 32'h3, 1'b0);
        start_sweep(0);

        repeat (3) cycle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dds_sweep_ctrl.md
DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 SHALL have parameter PHASE_WIDTH, default 32: width of the frequency and phase tuning words.
REQ-002 SHALL have parameter DWELL_WIDTH, default 16: width of the dwell counter.
REQ-003 SHALL have port clk, input, 1: the only clock; every register samples on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port cfg_valid, input, 1: the configuration offer.
REQ-006 SHALL have port cfg_ready, output, 1: configuration accepted; high only in IDLE.
REQ-007 SHALL have ports cfg_start_word / cfg_stop_word / cfg_step_word, input, PHASE_WIDTH each: sweep start, end and increment.
REQ-008 SHALL have port cfg_dwell, input, DWELL_WIDTH: each frequency is held cfg_dwell+1 cycles.
REQ-009 SHALL have port cfg_pha_word, input, PHASE_WIDTH: phase offset.
REQ-010 SHALL have port start, input, 1: the sweep-start pulse.
REQ-011 SHALL have port abort, input, 1: the sweep-cancel request.
REQ-012 SHALL have ports fre_word / pha_word, output, PHASE_WIDTH each: drive the DDS Fre_word and Pha_word inputs.
REQ-013 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-014 SHALL have port done, output, 1: a one-cycle pulse at sweep completion.

Function
REQ-015 SHALL latch all cfg_* inputs into shadow registers on the cycle where cfg_valid && cfg_ready, and set the internal flag cfg_loaded.
REQ-016 SHALL ignore start when cfg_loaded is 0 or when not in IDLE.
REQ-017 SHALL use the states IDLE, DWELL, STEP, DONE; IDLE --start--> DWELL; DWELL --cnt==dwell--> STEP or DONE; STEP --> DWELL; DONE --> IDLE.
REQ-018 SHALL, on the cycle after an accepted start, set fre_word = start_word, set pha_word = pha shadow, and zero the dwell counter.
REQ-019 SHALL increment the dwell counter each cycle in DWELL; the exit condition is cnt == dwell, so each word is held exactly dwell+1 cycles.
REQ-020 SHALL, in STEP, compute next = fre_word + step at PHASE_WIDTH+1 bits, unsigned, with no wrap.
REQ-021 SHALL, in STEP, load stop_word into fre_word if next >= stop_word, and load next otherwise; fre_word updates on the cycle after STEP.
REQ-022 SHALL go from DWELL to DONE (no STEP) when fre_word == stop_word.
REQ-023 SHALL treat start_word >= stop_word or step_word == 0 as a single dwell at start_word, then DONE.
REQ-024 SHALL assert done for exactly the one cycle spent in DONE, then enter IDLE.
REQ-025 SHALL hold fre_word and pha_word at their last values in DONE and IDLE.
REQ-026 SHALL make abort win over start and every other condition in the same cycle.
REQ-027 SHALL make abort in any state drive, next cycle: IDLE, fre_word=0, busy=0, no done pulse, cfg_loaded retained.
REQ-028 SHALL leave the shadow registers unchanged by cfg_valid while busy.
REQ-029 SHALL, when cfg_valid and start arrive in the same IDLE cycle with cfg_loaded=1, latch the new configuration and start with the old configuration.
REQ-030 SHALL have a start-to-first-fre_word latency of 1 cycle and a word-to-word period of dwell+2 cycles (dwell+1 in DWELL plus 1 in STEP).

Reset
REQ-031 SHALL, with rst_n=0 at a clock edge, set: state=IDLE, fre_word=0, pha_word=0, busy=0, done=0, cfg_ready=1 after release, cfg_loaded=0, shadow registers=0, dwell counter=0.
REQ-032 SHALL, on reset mid-sweep, abandon the sweep without a done pulse.

Configuration
REQ-033 SHALL, with macro DDS_SWEEP_TRIANGLE_EN defined, reach stop_word and then sweep down by step_word (saturating at start_word) before DONE; done pulses once per full up/down cycle.
REQ-034 SHALL, with DDS_SWEEP_TRIANGLE_EN not defined, perform an up-sweep only, per REQ-021/022, with no down-direction logic present.
REQ-035 SHALL keep abort, reset and degenerate-config behaviour (REQ-023, REQ-026/027) identical in both builds.

Verification
REQ-036 SHALL cover: start=100, stop=400, step=100, dwell=2, start pulse -> fre_word 100,200,300,400 each held 3 cycles with 1-cycle STEP between; done pulse 1 cycle after the 400 dwell.
REQ-037 SHALL cover: start=100, stop=350, step=100 -> sequence 100,200,300,350 (saturated); done once.
REQ-038 SHALL cover: step=0xFFFFFFF0, start=0x20, stop=0xFFFFFFFF -> the second word is 0xFFFFFFFF (no wrap to a small value), then done.
REQ-039 SHALL cover: abort during the second DWELL of REQ-036 -> next cycle fre_word=0, busy=0, no done; a later start reruns from 100.
REQ-040 SHALL cover: start with cfg_loaded=0 -> busy stays 0; cfg_valid while busy -> shadow registers unchanged.
REQ-041 SHALL cover, with DDS_SWEEP_TRIANGLE_EN defined: the REQ-036 config -> 100,200,300,400,300,200,100, then a single done pulse.
